// File: rtl/wb_port_arbiter_if.sv
// Register-file write-port bus: write-back stage, secondary requester, ID-stage
// hazard query and the registered write-port outputs of wb_port_arbiter.
interface wb_port_arbiter_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic                 wb_regWrite;
  logic                 wb_write_mux;
  logic [DATA_W-1:0]    wb_alu_data;
  logic [DATA_W-1:0]    wb_rs_data;
  logic [ADDR_W-1:0]    wb_rd;
  logic                 sec_valid;
  logic [ADDR_W-1:0]    sec_rd;
  logic [DATA_W-1:0]    sec_data;
  logic                 sec_ready;
  logic                 sec_issue;
  logic [ADDR_W-1:0]    sec_issue_rd;
  logic [ADDR_W-1:0]    id_rs;
  logic [ADDR_W-1:0]    id_rt;
  logic [ADDR_W-1:0]    id_rd;
  logic                 id_rd_we;
  logic                 hazard_stall;
  logic                 pipe_hold;
  logic                 rf_we;
  logic [ADDR_W-1:0]    rf_waddr;
  logic [DATA_W-1:0]    rf_wdata;
  logic [2**ADDR_W-1:0] pending_vec;
  logic [7:0]           perf_forced_cnt;

  modport slave (
    input  wb_regWrite, wb_write_mux, wb_alu_data, wb_rs_data, wb_rd,
    input  sec_valid, sec_rd, sec_data, sec_issue, sec_issue_rd,
    input  id_rs, id_rt, id_rd, id_rd_we,
    output sec_ready, hazard_stall, pipe_hold,
    output rf_we, rf_waddr, rf_wdata, pending_vec, perf_forced_cnt
  );

  modport master (
    output wb_regWrite, wb_write_mux, wb_alu_data, wb_rs_data, wb_rd,
    output sec_valid, sec_rd, sec_data, sec_issue, sec_issue_rd,
    output id_rs, id_rt, id_rd, id_rd_we,
    input  sec_ready, hazard_stall, pipe_hold,
    input  rf_we, rf_waddr, rf_wdata, pending_vec, perf_forced_cnt
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between write-back and a secondary
// requester, with a pending scoreboard and bounded starvation. Optional
// forced-grant counter is built when WBARB_PERF_EN is defined.
module wb_port_arbiter #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 3,
  parameter int STARVE_MAX = 4
) (
  input  logic             clock,
  input  logic             reset,
  wb_port_arbiter_if.slave bus
);
  localparam int         NREG       = 2**ADDR_W;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  function automatic logic [DATA_W-1:0] wb_select(input logic sel,
                                                  input logic [DATA_W-1:0] rs,
                                                  input logic [DATA_W-1:0] alu);
    return sel ? rs : alu;
  endfunction

  logic [3:0]        starve_q, starve_d;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic [NREG-1:0]   pending_q, pending_d;
  logic              at_limit, forced, sec_win, pipe_win;

  always_comb begin
    at_limit = (starve_q == STARVE_LIM);
    forced   = bus.wb_regWrite & bus.sec_valid & at_limit;
    sec_win  = bus.sec_valid & (~bus.wb_regWrite | at_limit);
    pipe_win = bus.wb_regWrite & ~forced;
  end

  always_comb begin
    // Starvation only accumulates while the pipeline beats a waiting request.
    starve_d   = (pipe_win & bus.sec_valid) ? starve_q + 4'd1 : 4'd0;
    rf_we_d    = sec_win | pipe_win;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (sec_win) begin
      rf_waddr_d = bus.sec_rd;
      rf_wdata_d = bus.sec_data;
    end else if (pipe_win) begin
      rf_waddr_d = bus.wb_rd;
      rf_wdata_d = wb_select(bus.wb_write_mux, bus.wb_rs_data, bus.wb_alu_data);
    end
    // Clear before set so a same-register issue in the grant cycle stays pending.
    pending_d = pending_q;
    if (sec_win)
      pending_d[bus.sec_rd] = 1'b0;
    if (bus.sec_issue)
      pending_d[bus.sec_issue_rd] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      pending_q  <= '0;
    end else begin
      starve_q   <= starve_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      pending_q  <= pending_d;
    end
  end

`ifdef WBARB_PERF_EN
  logic [7:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (forced && perf_q != 8'hFF)
      perf_d = perf_q + 8'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      perf_q <= '0;
    else
      perf_q <= perf_d;
  end

  assign bus.perf_forced_cnt = perf_q;
`else
  assign bus.perf_forced_cnt = 8'd0;
`endif

  assign bus.sec_ready    = sec_win;
  assign bus.pipe_hold    = forced;
  assign bus.hazard_stall = pending_q[bus.id_rs] | pending_q[bus.id_rt] |
                            (bus.id_rd_we & pending_q[bus.id_rd]);
  assign bus.rf_we        = rf_we_q;
  assign bus.rf_waddr     = rf_waddr_q;
  assign bus.rf_wdata     = rf_wdata_q;
  assign bus.pending_vec  = pending_q;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: stimulus pushes expected writes, a
// negedge monitor pops them whenever rf_we is presented.
module tb_wb_port_arbiter;
  typedef struct {
    logic [2:0] addr;
    logic [7:0] data;
  } wr_t;

  logic clock;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  wr_t  exp_q[$];
  logic [7:0] exp_perf;

  wb_port_arbiter_if #(.DATA_W(8), .ADDR_W(3)) bus ();

  wb_port_arbiter #(.DATA_W(8), .ADDR_W(3), .STARVE_MAX(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [2:0] a, input logic [7:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.wb_regWrite  = 1'b0;
    bus.wb_write_mux = 1'b0;
    bus.wb_alu_data  = 8'h00;
    bus.wb_rs_data   = 8'h00;
    bus.wb_rd        = 3'd0;
    bus.sec_valid    = 1'b0;
    bus.sec_rd       = 3'd0;
    bus.sec_data     = 8'h00;
    bus.sec_issue    = 1'b0;
    bus.sec_issue_rd = 3'd0;
  endtask

  always @(negedge clock) begin
    if (reset && bus.rf_we) begin
      wr_t e;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_write: got addr %0d data %0h expected no write",
                 bus.rf_waddr, bus.rf_wdata);
      end else begin
        e = exp_q.pop_front();
        if (bus.rf_waddr !== e.addr || bus.rf_wdata !== e.data) begin
          n_bad++;
          $display("FAIL rf_write: got addr %0d data %0h expected addr %0d data %0h",
                   bus.rf_waddr, bus.rf_wdata, e.addr, e.data);
        end
      end
    end
  end

  initial begin
`ifdef WBARB_PERF_EN
    exp_perf = 8'd1;
`else
    exp_perf = 8'd0;
`endif
    reset = 1'b0;
    idle();
    bus.id_rs = 3'd0; bus.id_rt = 3'd0; bus.id_rd = 3'd0; bus.id_rd_we = 1'b0;
    tick();
    chk("reset_rf_we", 32'(bus.rf_we), 32'd0);
    chk("reset_pending", 32'(bus.pending_vec), 32'h0);
    chk("reset_perf", 32'(bus.perf_forced_cnt), 32'd0);
    reset = 1'b1;

    // Build up state, then reset asynchronously mid-cycle.
    for (int i = 0; i < 4; i++) begin
      tick();
      bus.sec_issue = 1'b1; bus.sec_issue_rd = 3'(i);
      if (i == 3) begin
        bus.wb_regWrite = 1'b1; bus.wb_rd = 3'd1; bus.wb_alu_data = 8'h11;
      end
    end
    tick();
    idle();
    bus.id_rs = 3'd3;
    #1;
    chk("pre_reset_pending", 32'(bus.pending_vec), 32'h0F);
    chk("pre_reset_rf_we", 32'(bus.rf_we), 32'd1);
    chk("pre_reset_hazard", 32'(bus.hazard_stall), 32'd1);
    reset = 1'b0;
    #1;
    chk("async_rf_we", 32'(bus.rf_we), 32'd0);
    chk("async_pending", 32'(bus.pending_vec), 32'h0);
    chk("async_waddr", 32'(bus.rf_waddr), 32'd0);
    chk("async_wdata", 32'(bus.rf_wdata), 32'd0);
    chk("async_hazard", 32'(bus.hazard_stall), 32'd0);
    chk("async_perf", 32'(bus.perf_forced_cnt), 32'd0);
    tick();
    reset = 1'b1;
    bus.id_rs = 3'd0;

    // Pipeline writes, both data selects.
    tick();
    bus.wb_regWrite = 1'b1; bus.wb_write_mux = 1'b0; bus.wb_alu_data = 8'h3C; bus.wb_rd = 3'd5;
    #1;
    chk("pipe_sec_ready", 32'(bus.sec_ready), 32'd0);
    chk("pipe_hold_idle", 32'(bus.pipe_hold), 32'd0);
    push(3'd5, 8'h3C);
    tick();
    bus.wb_write_mux = 1'b1; bus.wb_rs_data = 8'hA5;
    push(3'd5, 8'hA5);
    tick();
    idle();
    tick();
    chk("hold_rf_we", 32'(bus.rf_we), 32'd0);
    chk("hold_waddr", 32'(bus.rf_waddr), 32'd5);
    chk("hold_wdata", 32'(bus.rf_wdata), 32'hA5);

    // Secondary write while write-back is idle.
    bus.sec_valid = 1'b1; bus.sec_rd = 3'd2; bus.sec_data = 8'h77;
    #1;
    chk("sec_idle_ready", 32'(bus.sec_ready), 32'd1);
    chk("sec_idle_hold", 32'(bus.pipe_hold), 32'd0);
    push(3'd2, 8'h77);
    tick();
    idle();

    // Starvation: four pipeline wins, forced grant on the fifth, pipeline on the sixth.
    for (int i = 1; i <= 4; i++) begin
      tick();
      bus.wb_regWrite = 1'b1; bus.wb_rd = 3'(i); bus.wb_alu_data = 8'(8'h10 + i);
      bus.sec_valid = 1'b1; bus.sec_rd = 3'd4; bus.sec_data = 8'h99;
      #1;
      chk($sformatf("starve%0d_ready", i), 32'(bus.sec_ready), 32'd0);
      chk($sformatf("starve%0d_hold", i), 32'(bus.pipe_hold), 32'd0);
      push(3'(i), 8'(8'h10 + i));
    end
    tick();
    bus.wb_rd = 3'd5; bus.wb_alu_data = 8'h55;
    #1;
    chk("forced_ready", 32'(bus.sec_ready), 32'd1);
    chk("forced_hold", 32'(bus.pipe_hold), 32'd1);
    push(3'd4, 8'h99);
    tick();
    bus.sec_rd = 3'd7; bus.sec_data = 8'h42;
    #1;
    chk("after_forced_ready", 32'(bus.sec_ready), 32'd0);
    chk("after_forced_hold", 32'(bus.pipe_hold), 32'd0);
    push(3'd5, 8'h55);
    tick();
    idle();
    chk("perf_forced", 32'(bus.perf_forced_cnt), 32'(exp_perf));

    // Scoreboard hazard on register 3 until its secondary write lands.
    bus.sec_issue = 1'b1; bus.sec_issue_rd = 3'd3;
    tick();
    bus.sec_issue = 1'b0; bus.id_rs = 3'd3;
    #1;
    chk("raw_stall_1", 32'(bus.hazard_stall), 32'd1);
    tick();
    bus.wb_regWrite = 1'b1; bus.wb_rd = 3'd0; bus.wb_alu_data = 8'h01;
    push(3'd0, 8'h01);
    #1;
    chk("raw_stall_2", 32'(bus.hazard_stall), 32'd1);
    tick();
    bus.wb_regWrite = 1'b0;
    bus.sec_valid = 1'b1; bus.sec_rd = 3'd3; bus.sec_data = 8'h33;
    #1;
    chk("raw_grant_ready", 32'(bus.sec_ready), 32'd1);
    chk("raw_stall_grant", 32'(bus.hazard_stall), 32'd1);
    push(3'd3, 8'h33);
    tick();
    idle();
    #1;
    chk("raw_cleared_stall", 32'(bus.hazard_stall), 32'd0);
    chk("raw_cleared_pending", 32'(bus.pending_vec), 32'h0);

    // WAW via id_rd with id_rd_we, and the id_rt source.
    bus.sec_issue = 1'b1; bus.sec_issue_rd = 3'd1;
    tick();
    bus.sec_issue = 1'b0;
    bus.id_rs = 3'd0; bus.id_rt = 3'd0; bus.id_rd = 3'd1; bus.id_rd_we = 1'b0;
    #1;
    chk("waw_no_we", 32'(bus.hazard_stall), 32'd0);
    bus.id_rd_we = 1'b1;
    #1;
    chk("waw_we", 32'(bus.hazard_stall), 32'd1);
    bus.id_rd_we = 1'b0; bus.id_rt = 3'd1;
    #1;
    chk("rt_stall", 32'(bus.hazard_stall), 32'd1);
    bus.id_rt = 3'd0; bus.id_rd = 3'd0;

    // Issue and grant to register 6 in the same cycle: set wins.
    bus.sec_valid = 1'b1; bus.sec_rd = 3'd6; bus.sec_data = 8'h66;
    bus.sec_issue = 1'b1; bus.sec_issue_rd = 3'd6;
    #1;
    chk("setwin_ready", 32'(bus.sec_ready), 32'd1);
    push(3'd6, 8'h66);
    tick();
    idle();
    #1;
    chk("setwin_pending", 32'(bus.pending_vec), 32'h42);
    bus.sec_valid = 1'b1; bus.sec_rd = 3'd1; bus.sec_data = 8'h0A;
    push(3'd1, 8'h0A);
    tick();
    bus.sec_rd = 3'd6; bus.sec_data = 8'h0B;
    push(3'd6, 8'h0B);
    tick();
    idle();
    #1;
    chk("final_pending", 32'(bus.pending_vec), 32'h0);
    tick();
    tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
